// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 scheduler and driver: state encoding, bus widths, colour scaling.
// The scale_rgb helper is only referenced when WS2812_BRIGHTNESS_EN is defined.
package ws2812_pkg;

  localparam int unsigned LED_W = 8;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned CH_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FILL    = 2'd2,
    ST_REFRESH = 2'd3
  } ws_state_t;

  typedef struct packed {
    logic             fill;
    logic [LED_W-1:0] led;
    logic [RGB_W-1:0] rgb;
  } ws_cmd_t;

  // Per-channel (c * (level + 1)) >> 8, so level 255 is identity and level 0 is black.
  function automatic logic [RGB_W-1:0] scale_rgb(input logic [RGB_W-1:0] rgb,
                                                 input logic [CH_W-1:0]  level);
    logic [RGB_W-1:0] scaled;
    scaled = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      scaled[c*CH_W +: CH_W] = CH_W'(((16'(rgb[c*CH_W +: CH_W])) *
                                      (16'(level) + 16'd1)) >> 8);
    end
    return scaled;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int unsigned      idx;
  logic [PTR_W-1:0] idx_w;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2812_sched.sv
// Arbitrates pixel-write/fill commands from several requesters onto a single ws2812 driver port.
// Optional global brightness scaling at capture is enabled by defining WS2812_BRIGHTNESS_EN.
module ws2812_sched
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned NUM_REQ  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_fill,
  input  logic [NUM_REQ*8-1:0]   req_led,
  input  logic [NUM_REQ*24-1:0]  req_rgb,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   refresh,
  input  logic [7:0]             brightness,
  output logic [23:0]            ws_rgb_data,
  output logic [7:0]             ws_led_num,
  output logic                   ws_write,
  output logic                   ws_reset,
  output logic                   busy,
  output logic                   drop
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

  ws_state_t          state;
  logic [PTR_W-1:0]   ptr;
  logic               pending;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   sel_idx;
  ws_cmd_t            sel_cmd;
  logic               accept_open;
  logic               transfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Requests are only offered when idle and no refresh is waiting.
  assign accept_open = (state == ST_IDLE) && !pending;
  assign req_ready   = accept_open ? grant : '0;
  assign transfer    = |req_ready;
  assign busy        = (state != ST_IDLE) || pending;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_idx = PTR_W'(i);
    end
  end

  always_comb begin
    sel_cmd.fill = req_fill[sel_idx];
    sel_cmd.led  = req_led[32'(sel_idx)*LED_W +: LED_W];
`ifdef WS2812_BRIGHTNESS_EN
    sel_cmd.rgb  = scale_rgb(req_rgb[32'(sel_idx)*RGB_W +: RGB_W], brightness);
`else
    sel_cmd.rgb  = req_rgb[32'(sel_idx)*RGB_W +: RGB_W];
`endif
  end

`ifndef WS2812_BRIGHTNESS_EN
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      pending     <= 1'b0;
      ws_write    <= 1'b0;
      ws_reset    <= 1'b0;
      drop        <= 1'b0;
      ws_rgb_data <= '0;
      ws_led_num  <= '0;
    end else begin
      pending     <= pending | refresh;
      ws_write    <= 1'b0;
      ws_reset    <= 1'b0;
      drop        <= 1'b0;
      ws_rgb_data <= '0;
      ws_led_num  <= '0;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state    <= ST_REFRESH;
            ws_reset <= 1'b1;
            pending  <= refresh;
          end else if (transfer) begin
            ptr <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
            if (sel_cmd.fill) begin
              state       <= ST_FILL;
              ws_write    <= 1'b1;
              ws_rgb_data <= sel_cmd.rgb;
            end else begin
              state <= ST_WRITE;
              if (32'(sel_cmd.led) < NUM_LEDS) begin
                ws_write    <= 1'b1;
                ws_led_num  <= sel_cmd.led;
                ws_rgb_data <= sel_cmd.rgb;
              end else begin
                drop <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: state <= ST_IDLE;
        // Output registers double as the fill cursor and colour hold.
        ST_FILL: begin
          if (ws_led_num == LAST_LED) begin
            state <= ST_IDLE;
          end else begin
            ws_write    <= 1'b1;
            ws_rgb_data <= ws_rgb_data;
            ws_led_num  <= ws_led_num + LED_W'(1);
          end
        end
        ST_REFRESH: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_sched.sv
// Directed self-checking bench for ws2812_sched (NUM_LEDS=8, NUM_REQ=2).
module tb_ws2812_sched;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_fill;
  logic [15:0] req_led;
  logic [47:0] req_rgb;
  logic [1:0]  req_ready;
  logic        refresh;
  logic [7:0]  brightness;
  logic [23:0] ws_rgb_data;
  logic [7:0]  ws_led_num;
  logic        ws_write;
  logic        ws_reset;
  logic        busy;
  logic        drop;

  int checks;
  int errors;

  ws2812_sched #(.NUM_LEDS(8), .NUM_REQ(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_fill    (req_fill),
    .req_led     (req_led),
    .req_rgb     (req_rgb),
    .req_ready   (req_ready),
    .refresh     (refresh),
    .brightness  (brightness),
    .ws_rgb_data (ws_rgb_data),
    .ws_led_num  (ws_led_num),
    .ws_write    (ws_write),
    .ws_reset    (ws_reset),
    .busy        (busy),
    .drop        (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic f,
                         input logic [7:0] led, input logic [23:0] rgb);
    req_valid[i]        = v;
    req_fill[i]         = f;
    req_led[i*8 +: 8]   = led;
    req_rgb[i*24 +: 24] = rgb;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    refresh   = 1'b1;
    req_valid = 2'b11;
    reset     = 1'b1;
    step();
    step();
    refresh   = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++;
    if ({ws_write, ws_reset, drop, busy} !== 4'b0000 || ws_rgb_data !== 24'h0 || ws_led_num !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: write=%b rst=%b drop=%b busy=%b rgb=%h led=%h, required all zero",
               ws_write, ws_reset, drop, busy, ws_rgb_data, ws_led_num);
    end
    reset = 1'b0;
    step();
    set_req(0, 1'b1, 1'b0, 8'd1, 24'h0);
    set_req(1, 1'b1, 1'b0, 8'd2, 24'h0);
    #1;
    checks++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr: ready=%b busy=%b, required ready=01 busy=0", req_ready, busy);
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 1'b0, 8'd3, 24'h00FF00);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: ready=%b, required 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (ws_write !== 1'b1 || ws_led_num !== 8'd3 || ws_rgb_data !== 24'h00FF00 || busy !== 1'b1 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_write: write=%b led=%0d rgb=%h busy=%b ready=%b, required 1 3 00ff00 1 00",
               ws_write, ws_led_num, ws_rgb_data, busy, req_ready);
    end
    step();
    checks++;
    if (ws_write !== 1'b0 || busy !== 1'b0 || ws_led_num !== 8'd0 || ws_rgb_data !== 24'h0) begin
      errors++;
      $display("FAIL single_idle: write=%b busy=%b led=%0d rgb=%h, required 0 0 0 0",
               ws_write, busy, ws_led_num, ws_rgb_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ready;
    int         last_grant;
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'd1, 24'h111111);
    set_req(1, 1'b1, 1'b0, 8'd2, 24'h222222);
    last_grant = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        exp_ready = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
        last_grant = ((k / 2) % 2 == 0) ? 0 : 1;
        checks++;
        if (req_ready !== exp_ready) begin
          errors++;
          $display("FAIL contention_grant k=%0d: ready=%b, required %b", k, req_ready, exp_ready);
        end
      end else begin
        checks++;
        if (ws_write !== 1'b1 || ws_led_num !== 8'(last_grant + 1) || req_ready !== 2'b00) begin
          errors++;
          $display("FAIL contention_write k=%0d: write=%b led=%0d ready=%b, required 1 %0d 00",
                   k, ws_write, ws_led_num, req_ready, last_grant + 1);
        end
      end
      if (k == 7) req_valid = 2'b00;
      step();
    end
  endtask

  task automatic test_fill();
    set_req(1, 1'b1, 1'b1, 8'h55, 24'h0A0B0C);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL fill_ready: ready=%b, required 10", req_ready);
    end
    step();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'd4, 24'h010203);
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ws_write !== 1'b1 || ws_led_num !== 8'(i) || ws_rgb_data !== 24'h0A0B0C || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL fill_cycle %0d: write=%b led=%0d rgb=%h ready=%b, required 1 %0d 0a0b0c 00",
                 i, ws_write, ws_led_num, ws_rgb_data, req_ready, i);
      end
      step();
    end
    checks++;
    if (ws_write !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL fill_end: write=%b ready=%b, required 0 01", ws_write, req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (ws_write !== 1'b1 || ws_led_num !== 8'd4 || ws_rgb_data !== 24'h010203) begin
      errors++;
      $display("FAIL fill_followup: write=%b led=%0d rgb=%h, required 1 4 010203",
               ws_write, ws_led_num, ws_rgb_data);
    end
    step();
  endtask

  task automatic test_refresh_during_fill();
    int resets_seen;
    resets_seen = 0;
    set_req(1, 1'b1, 1'b1, 8'h00, 24'h123456);
    #1;
    step();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'd6, 24'h654321);
    for (int i = 0; i < 8; i++) begin
      refresh = (i == 2 || i == 5);
      #1;
      if (ws_reset) resets_seen++;
      step();
      refresh = 1'b0;
    end
    #1;
    checks++;
    if (ws_reset !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1 || ws_write !== 1'b0) begin
      errors++;
      $display("FAIL refresh_pending: rst=%b ready=%b busy=%b write=%b, required 0 00 1 0",
               ws_reset, req_ready, busy, ws_write);
    end
    step();
    checks++;
    if (ws_reset !== 1'b1 || req_ready !== 2'b00 || ws_write !== 1'b0) begin
      errors++;
      $display("FAIL refresh_pulse: rst=%b ready=%b write=%b, required 1 00 0", ws_reset, req_ready, ws_write);
    end
    step();
    checks++;
    if (ws_reset !== 1'b0 || req_ready !== 2'b01 || resets_seen != 0) begin
      errors++;
      $display("FAIL refresh_single: rst=%b ready=%b early_resets=%0d, required 0 01 0",
               ws_reset, req_ready, resets_seen);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (ws_write !== 1'b1 || ws_led_num !== 8'd6 || ws_reset !== 1'b0) begin
      errors++;
      $display("FAIL refresh_next_grant: write=%b led=%0d rst=%b, required 1 6 0", ws_write, ws_led_num, ws_reset);
    end
    step();
  endtask

  task automatic test_drop();
    set_req(0, 1'b1, 1'b0, 8'd8, 24'hFFFFFF);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL drop_ready: ready=%b, required 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (drop !== 1'b1 || ws_write !== 1'b0 || ws_rgb_data !== 24'h0 || ws_led_num !== 8'h0) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b write=%b rgb=%h led=%0d, required 1 0 0 0",
               drop, ws_write, ws_rgb_data, ws_led_num);
    end
    step();
    checks++;
    if (drop !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: drop=%b busy=%b, required 0 0", drop, busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    set_req(1, 1'b1, 1'b1, 8'h00, 24'hABCDEF);
    #1;
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    checks++;
    if (ws_write !== 1'b1 || ws_led_num !== 8'd3) begin
      errors++;
      $display("FAIL midfill_pre: write=%b led=%0d, required 1 3", ws_write, ws_led_num);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ws_write !== 1'b0 || busy !== 1'b0 || ws_led_num !== 8'd0) begin
      errors++;
      $display("FAIL midfill_abort: write=%b busy=%b led=%0d, required 0 0 0", ws_write, busy, ws_led_num);
    end
    step();
    set_req(0, 1'b1, 1'b0, 8'd0, 24'h0);
    set_req(1, 1'b1, 1'b0, 8'd0, 24'h0);
    #1;
    checks++;
    if (ws_write !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midfill_idle: write=%b ready=%b, required 0 01", ws_write, req_ready);
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_refresh_with_transfer();
    set_req(0, 1'b1, 1'b0, 8'd5, 24'h0F0F0F);
    refresh = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rwt_ready: ready=%b, required 01", req_ready);
    end
    step();
    refresh   = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++;
    if (ws_write !== 1'b1 || ws_led_num !== 8'd5 || ws_reset !== 1'b0) begin
      errors++;
      $display("FAIL rwt_write: write=%b led=%0d rst=%b, required 1 5 0", ws_write, ws_led_num, ws_reset);
    end
    step();
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || ws_reset !== 1'b0) begin
      errors++;
      $display("FAIL rwt_pending: ready=%b busy=%b rst=%b, required 00 1 0", req_ready, busy, ws_reset);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (ws_reset !== 1'b1 || ws_write !== 1'b0) begin
      errors++;
      $display("FAIL rwt_reset: rst=%b write=%b, required 1 0", ws_reset, ws_write);
    end
    step();
    checks++;
    if (ws_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rwt_done: rst=%b busy=%b, required 0 0", ws_reset, busy);
    end
  endtask

  task automatic test_brightness();
    logic [23:0] exp_rgb;
`ifdef WS2812_BRIGHTNESS_EN
    exp_rgb = 24'h7F4020;
`else
    exp_rgb = 24'hFF8040;
`endif
    brightness = 8'd127;
    set_req(0, 1'b1, 1'b0, 8'd2, 24'hFF8040);
    set_req(1, 1'b0, 1'b0, 8'd0, 24'h0);
    #1;
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (ws_write !== 1'b1 || ws_rgb_data !== exp_rgb) begin
      errors++;
      $display("FAIL brightness: write=%b rgb=%h, required 1 %h", ws_write, ws_rgb_data, exp_rgb);
    end
    step();
    brightness = 8'd255;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_fill   = '0;
    req_led    = '0;
    req_rgb    = '0;
    refresh    = 1'b0;
    brightness = 8'd255;
    test_reset();
    test_single();
    test_contention();
    test_fill();
    test_refresh_during_fill();
    test_drop();
    test_reset_mid_fill();
    test_refresh_with_transfer();
    test_brightness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_sched.md
WS2812_SCHED -- requirements
Module: ws2812_sched

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of LEDs in the chain driven by the downstream ws2812 driver.
REQ-002 Parameter NUM_REQ, default 2, number of pixel-write requesters.
REQ-003 clk  input  1  single system clock (12 MHz); all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester command valid.
REQ-006 req_fill  input  NUM_REQ  per-requester command type: 0 single pixel, 1 fill all LEDs.
REQ-007 req_led  input  NUM_REQ*8  per-requester LED index, slice i at [8i+7:8i].
REQ-008 req_rgb  input  NUM_REQ*24  per-requester colour, slice i at [24i+23:24i], GRB order as the driver expects.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; a command transfers when valid and ready are both high.
REQ-010 refresh  input  1  single-cycle request to restart frame output.
REQ-011 brightness  input  8  global scale; ignored unless WS2812_BRIGHTNESS_EN is defined.
REQ-012 ws_rgb_data  output  24  to driver rgb_data.
REQ-013 ws_led_num  output  8  to driver led_num.
REQ-014 ws_write  output  1  to driver write.
REQ-015 ws_reset  output  1  to driver reset.
REQ-016 busy  output  1  high whenever state is not IDLE or a refresh is pending.
REQ-017 drop  output  1  one-cycle pulse when an accepted single command has req_led >= NUM_LEDS.

Function
REQ-018 States SHALL be IDLE, WRITE, FILL, REFRESH.
REQ-019 In IDLE with no pending refresh, req_ready SHALL be asserted combinationally for exactly one requester: the first valid one at or after the round-robin pointer; all others low.
REQ-020 On transfer from requester i, the pointer SHALL become (i+1) mod NUM_REQ; it SHALL not change without a transfer.
REQ-021 req_ready SHALL be all-zero outside IDLE or while a refresh is pending.
REQ-022 Single command: next cycle state WRITE, ws_write=1 for exactly one cycle carrying the captured led/rgb, then IDLE; total two cycles per command.
REQ-023 Single command with led >= NUM_LEDS: accepted, no ws_write, drop pulses in the WRITE cycle.
REQ-024 Fill command: state FILL for NUM_LEDS consecutive cycles, ws_write=1 each cycle, ws_led_num 0,1,...,NUM_LEDS-1, constant captured rgb; req_led ignored; then IDLE.
REQ-025 refresh SHALL set a sticky pending flag in any state; multiple pulses before service merge into one.
REQ-026 In IDLE a pending refresh SHALL take priority over requests: enter REFRESH, ws_reset=1 for exactly one cycle, clear pending, return to IDLE.
REQ-027 refresh arriving in the same cycle as a transfer SHALL not cancel the transfer; the refresh is serviced after it completes.
REQ-028 ws_rgb_data and ws_led_num SHALL be zero whenever ws_write is low.

Reset
REQ-029 reset SHALL force state IDLE, pointer 0, pending refresh cleared, and ws_write, ws_reset, drop, ws_rgb_data, ws_led_num, busy all 0 in the following cycle.
REQ-030 reset mid-WRITE or mid-FILL SHALL abort with no further ws_write pulses.

Configuration
REQ-031 With WS2812_BRIGHTNESS_EN defined, each 8-bit channel c SHALL be captured as (c*(brightness+1))>>8 at transfer (brightness 255 is identity, 0 yields 0), with no added latency.
REQ-032 Without WS2812_BRIGHTNESS_EN, rgb SHALL pass unmodified and brightness SHALL be unused.

Structure
REQ-033 Package ws2812_pkg SHALL hold the state encoding, LED index width (8) and RGB width (24), shared with the driver.
REQ-034 Arbitration SHALL be a sub-module rr_arbiter (NUM_REQ requests, pointer, one-hot grant).

Verification
REQ-035 Single: req0 valid led=3 rgb=0x00FF00 -> ready0 one cycle; next cycle ws_write=1, led=3, rgb=0x00FF00; IDLE after.
REQ-036 Contention: req0 and req1 valid continuously, pointer 0 -> grants 0,1,0,1 alternating, every two cycles.
REQ-037 Fill: req1 fill rgb=0x0A0B0C, NUM_LEDS=8 -> 8 consecutive ws_write, led 0..7, same rgb, ready low throughout.
REQ-038 Refresh during fill: refresh pulsed twice at fill cycles 2 and 5 -> single ws_reset one cycle after FILL ends, before next grant.
REQ-039 Out of range: single led=8 -> drop=1 one cycle, no ws_write; reset at fill cycle 3 -> ws_write 0 next cycle, state IDLE.
REQ-040 With WS2812_BRIGHTNESS_EN, brightness=127, rgb=0xFF8040 -> ws_rgb_data=0x7F4020.
